// File: rtl/vx_perf_memsys_csr_pkg.sv
// Shared GPU definitions: memory-system counter indices and CSR address map.
// Used by the CSR unit and the memsys counter read endpoint.
package VX_gpu_pkg;

  localparam int PERF_CTR_BITS   = 44;
  localparam int NUM_MEMSYS_CTRS = 14;

  localparam logic [11:0] MEMSYS_LO_BASE = 12'hB03;
  localparam logic [11:0] MEMSYS_HI_BASE = 12'hB83;

  typedef enum logic [3:0] {
    MS_ICACHE_READS,
    MS_ICACHE_READ_MISSES,
    MS_DCACHE_READS,
    MS_DCACHE_WRITES,
    MS_DCACHE_READ_MISSES,
    MS_DCACHE_WRITE_MISSES,
    MS_DCACHE_BANK_STALLS,
    MS_DCACHE_MSHR_STALLS,
    MS_SMEM_READS,
    MS_SMEM_WRITES,
    MS_SMEM_BANK_STALLS,
    MS_MEM_READS,
    MS_MEM_WRITES,
    MS_MEM_LATENCY
  } memsys_ctr_e;

  function automatic logic [31:0] ctr_hi(input logic [63:0] c);
    return c[63:32];
  endfunction

endpackage

// File: rtl/vx_perf_memsys_csr_if.sv
// Memory-system performance counter bundle.
// Producers drive the master side, readers use the slave side.
interface VX_perf_memsys_if
  import VX_gpu_pkg::*;
#(
  parameter int CTR_BITS = PERF_CTR_BITS
);

  logic [CTR_BITS-1:0] icache_reads;
  logic [CTR_BITS-1:0] icache_read_misses;
  logic [CTR_BITS-1:0] dcache_reads;
  logic [CTR_BITS-1:0] dcache_writes;
  logic [CTR_BITS-1:0] dcache_read_misses;
  logic [CTR_BITS-1:0] dcache_write_misses;
  logic [CTR_BITS-1:0] dcache_bank_stalls;
  logic [CTR_BITS-1:0] dcache_mshr_stalls;
  logic [CTR_BITS-1:0] smem_reads;
  logic [CTR_BITS-1:0] smem_writes;
  logic [CTR_BITS-1:0] smem_bank_stalls;
  logic [CTR_BITS-1:0] mem_reads;
  logic [CTR_BITS-1:0] mem_writes;
  logic [CTR_BITS-1:0] mem_latency;

  modport master (
    output icache_reads, icache_read_misses,
    output dcache_reads, dcache_writes,
    output dcache_read_misses, dcache_write_misses,
    output dcache_bank_stalls, dcache_mshr_stalls,
    output smem_reads, smem_writes, smem_bank_stalls,
    output mem_reads, mem_writes, mem_latency
  );

  modport slave (
    input icache_reads, icache_read_misses,
    input dcache_reads, dcache_writes,
    input dcache_read_misses, dcache_write_misses,
    input dcache_bank_stalls, dcache_mshr_stalls,
    input smem_reads, smem_writes, smem_bank_stalls,
    input mem_reads, mem_writes, mem_latency
  );

endinterface

// File: rtl/vx_perf_memsys_csr_buf.sv
// Single-entry elastic output stage; accepts a new beat
// in the same cycle the held one drains.
module VX_pipe_buffer #(
  parameter int DATAW = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [DATAW-1:0] data_out
);

  logic accept;

  assign ready_in = !valid_out || ready_out;
  assign accept   = valid_in && ready_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (accept) begin
      valid_out <= 1'b1;
      data_out  <= data_in;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/vx_perf_memsys_csr.sv
// Memsys perf counter CSR read endpoint with high-word snapshot
// so a low-then-high read pair sees one coherent counter value.
module vx_perf_memsys_csr
  import VX_gpu_pkg::*;
#(
  parameter int CTR_BITS   = PERF_CTR_BITS,
  parameter int ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] LO_BASE =
    ADDR_WIDTH'(MEMSYS_LO_BASE),
  parameter logic [ADDR_WIDTH-1:0] HI_BASE =
    ADDR_WIDTH'(MEMSYS_HI_BASE)
) (
  input  logic                  clk,
  input  logic                  reset,
  VX_perf_memsys_if.slave       perf_memsys_if,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  input  logic                  rsp_ready
);

  logic [CTR_BITS-1:0] ctr [16];
  logic [31:0] lo_word [16];
  logic [31:0] hi_word [16];

  assign ctr[MS_ICACHE_READS]        = perf_memsys_if.icache_reads;
  assign ctr[MS_ICACHE_READ_MISSES]  = perf_memsys_if.icache_read_misses;
  assign ctr[MS_DCACHE_READS]        = perf_memsys_if.dcache_reads;
  assign ctr[MS_DCACHE_WRITES]       = perf_memsys_if.dcache_writes;
  assign ctr[MS_DCACHE_READ_MISSES]  = perf_memsys_if.dcache_read_misses;
  assign ctr[MS_DCACHE_WRITE_MISSES] = perf_memsys_if.dcache_write_misses;
  assign ctr[MS_DCACHE_BANK_STALLS]  = perf_memsys_if.dcache_bank_stalls;
  assign ctr[MS_DCACHE_MSHR_STALLS]  = perf_memsys_if.dcache_mshr_stalls;
  assign ctr[MS_SMEM_READS]          = perf_memsys_if.smem_reads;
  assign ctr[MS_SMEM_WRITES]         = perf_memsys_if.smem_writes;
  assign ctr[MS_SMEM_BANK_STALLS]    = perf_memsys_if.smem_bank_stalls;
  assign ctr[MS_MEM_READS]           = perf_memsys_if.mem_reads;
  assign ctr[MS_MEM_WRITES]          = perf_memsys_if.mem_writes;
  assign ctr[MS_MEM_LATENCY]         = perf_memsys_if.mem_latency;
  // pad to a power of two so a 4-bit index never leaves the array
  assign ctr[14] = '0;
  assign ctr[15] = '0;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      lo_word[i] = ctr[i][31:0];
      hi_word[i] = ctr_hi(64'(ctr[i]));
    end
  end

  logic [ADDR_WIDTH-1:0] lo_off, hi_off;
  logic [3:0]  lo_idx, hi_idx;
  logic        lo_sel, hi_sel;
  logic [31:0] shadow_hi;
  logic [3:0]  shadow_idx;
  logic        shadow_vld;
  logic        hi_match;
  logic        accept;
  logic [31:0] rd_data;
  logic        rd_err;

  assign lo_off = req_addr - LO_BASE;
  assign hi_off = req_addr - HI_BASE;
  assign lo_idx = lo_off[3:0];
  assign hi_idx = hi_off[3:0];
  assign lo_sel = lo_off < ADDR_WIDTH'(NUM_MEMSYS_CTRS);
  assign hi_sel = !lo_sel &&
                  (hi_off < ADDR_WIDTH'(NUM_MEMSYS_CTRS));

  assign hi_match = shadow_vld && (shadow_idx == hi_idx);
  assign accept   = req_valid && req_ready;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (1'b1)
      lo_sel:  rd_data = lo_word[lo_idx];
      hi_sel:  rd_data = hi_match ? shadow_hi
                                  : hi_word[hi_idx];
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_hi  <= '0;
      shadow_idx <= '0;
      shadow_vld <= 1'b0;
    end else if (accept && lo_sel) begin
      shadow_hi  <= hi_word[lo_idx];
      shadow_idx <= lo_idx;
      shadow_vld <= 1'b1;
    end else if (accept && hi_sel && hi_match) begin
      shadow_vld <= 1'b0;
    end
  end

  VX_pipe_buffer #(
    .DATAW (33)
  ) rsp_buf (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (req_valid),
    .ready_in  (req_ready),
    .data_in   ({rd_err, rd_data}),
    .valid_out (rsp_valid),
    .ready_out (rsp_ready),
    .data_out  ({rsp_err, rsp_data})
  );

endmodule

// File: tb/tb_vx_perf_memsys_csr.sv
// Directed bench for vx_perf_memsys_csr with a response scoreboard.
// Inputs change on negedge; outputs are sampled between edges.
module tb_vx_perf_memsys_csr;

  localparam logic [11:0] LO = 12'hB03;
  localparam logic [11:0] HI = 12'hB83;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [11:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
  logic [43:0] cv [14];

  always #5 clk = ~clk;

  VX_perf_memsys_if #(.CTR_BITS(44)) pmif ();

  assign pmif.icache_reads        = cv[0];
  assign pmif.icache_read_misses  = cv[1];
  assign pmif.dcache_reads        = cv[2];
  assign pmif.dcache_writes       = cv[3];
  assign pmif.dcache_read_misses  = cv[4];
  assign pmif.dcache_write_misses = cv[5];
  assign pmif.dcache_bank_stalls  = cv[6];
  assign pmif.dcache_mshr_stalls  = cv[7];
  assign pmif.smem_reads          = cv[8];
  assign pmif.smem_writes         = cv[9];
  assign pmif.smem_bank_stalls    = cv[10];
  assign pmif.mem_reads           = cv[11];
  assign pmif.mem_writes          = cv[12];
  assign pmif.mem_latency         = cv[13];

  vx_perf_memsys_csr dut (
    .clk            (clk),
    .reset          (reset),
    .perf_memsys_if (pmif),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .rsp_ready      (rsp_ready)
  );

  int vectors = 0;
  int miscompares = 0;
  int popped = 0;
  int cyc = 0;
  logic [32:0] sbq [$];
  logic [32:0] mon_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard consumer: a response retires when valid && ready
  always @(negedge clk) begin
    #2;
    if (!reset && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_rsp: observed %h expected none",
               {rsp_err, rsp_data});
      end else begin
        mon_exp = sbq.pop_front();
        check("rsp", {31'b0, rsp_err, rsp_data}, 64'(mon_exp));
        popped++;
      end
    end
  end

  task automatic issue(input logic [11:0] a,
                       input logic [31:0] d,
                       input logic e);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    #2;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $error("FAIL accept_timeout: observed no accept expected accept");
    end
    sbq.push_back({e, d});
    @(negedge clk);
    check("latency", 64'(rsp_valid), 64'd1);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $error("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int c0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) cv[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_data", 64'(rsp_data), 64'd0);
    check("rst_err", 64'(rsp_err), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    // basic low/high
    cv[2] = 44'h123_4567_89AB;
    issue(12'(LO + 2), 32'h4567_89AB, 1'b0);
    issue(12'(HI + 2), 32'h0000_0123, 1'b0);
    idle();

    // coherence across a carry into the high word
    cv[0] = 44'h0_FFFF_FFFF;
    issue(LO, 32'hFFFF_FFFF, 1'b0);
    cv[0] = 44'h1_0000_0000;
    issue(HI, 32'h0, 1'b0);
    issue(HI, 32'h1, 1'b0);
    idle();

    // unmapped reads leave the shadow alone
    cv[5] = 44'hABC_0000_0001;
    issue(12'(LO + 5), 32'h1, 1'b0);
    cv[5] = 44'hDEF_0000_0002;
    issue(12'(LO + 14), 32'h0, 1'b1);
    issue(12'(HI + 14), 32'h0, 1'b1);
    issue(12'(LO - 1), 32'h0, 1'b1);
    issue(12'(HI + 5), 32'h0000_0ABC, 1'b0);
    idle();

    // back-to-back lows: shadow follows the last one
    cv[7] = 44'h011_0000_0007;
    cv[8] = 44'h022_0000_0008;
    issue(12'(LO + 7), 32'h7, 1'b0);
    issue(12'(LO + 8), 32'h8, 1'b0);
    cv[7] = 44'h033_0000_0007;
    cv[8] = 44'h044_0000_0008;
    issue(12'(HI + 7), 32'h033, 1'b0);
    issue(12'(HI + 8), 32'h022, 1'b0);
    idle();

    // backpressure
    rsp_ready = 1'b0;
    cv[9]  = 44'h0_0000_0009;
    cv[10] = 44'h0_0000_000A;
    issue(12'(LO + 9), 32'h9, 1'b0);
    req_valid = 1'b1;
    req_addr  = 12'(LO + 10);
    for (int k = 0; k < 5; k++) begin
      #2;
      check("bp_ready", 64'(req_ready), 64'd0);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_data", 64'(rsp_data), 64'h9);
      @(negedge clk);
    end
    p0 = popped;
    rsp_ready = 1'b1;
    issue(12'(LO + 10), 32'hA, 1'b0);
    idle();
    check("bp_count", 64'(popped - p0), 64'd2);

    // streaming
    for (int i = 0; i < 14; i++)
      cv[i] = {12'(i + 1), 32'h5000_0000 + 32'(i)};
    p0 = popped;
    c0 = cyc;
    for (int i = 0; i < 14; i++)
      issue(12'(LO + 12'(i)), 32'h5000_0000 + 32'(i), 1'b0);
    check("stream_cycles", 64'(cyc - c0), 64'd14);
    idle();
    check("stream_count", 64'(popped - p0), 64'd14);

    // reset with a response pending and a live shadow
    cv[3] = 44'h777_0000_0003;
    rsp_ready = 1'b0;
    issue(12'(LO + 3), 32'h3, 1'b0);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_data", 64'(rsp_data), 64'd0);
    check("mid_rst_err", 64'(rsp_err), 64'd0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    cv[3] = 44'h888_0000_0003;
    issue(12'(HI + 3), 32'h888, 1'b0);
    idle();
    idle();

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
